// File: rtl/blvds_tx_scheduler_pkg.sv
// Shared definitions for the BLVDS transmit scheduler: trigger-source mode
// encodings, scheduler FSM states and a small constant helper.
package blvds_tx_scheduler_pkg;

  // Trigger source selected by imode
  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_OFF      = 2'd3
  } mode_e;

  // Frame handshake sequencing with the generator
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Frames per burst come in on an 8-bit port
  localparam int BURST_W = 8;

  // Larger of two elaboration-time constants, used to size the shared wait counter
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/blvds_tx_scheduler_period_timer.sv
// Free-running periodic trigger timer. Counts 0..period-1 while enabled and
// emits a one-cycle tick on the terminal count. A period shrunk below the
// current count ticks immediately and wraps, so a new period is picked up
// without waiting for a stale count to run out.
module blvds_period_timer
  import blvds_tx_scheduler_pkg::*;
#(
  parameter int PERIOD_W = 26
) (
  input  logic                iclk,
  input  logic                ireset_n,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_count;
  logic                w_last;

  // Terminal count reached (or passed, after the period was lowered)
  assign w_last = (r_count >= (i_period - PERIOD_W'(1)));
  assign o_tick = i_enable && w_last;

  // Count while enabled, wrap on terminal count, hold at zero when disabled
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_count <= '0;
    end else if (!i_enable || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/blvds_tx_scheduler.sv
// Frame transmission scheduler for the BLVDS frame generator (56 MHz domain).
// Merges manual strobe, periodic timer and N-frame burst triggers into single
// cycle start pulses, handshakes with the generator busy flag, and keeps
// saturating statistics plus a sticky timeout flag.
module blvds_tx_scheduler
  import blvds_tx_scheduler_pkg::*;
#(
  parameter int PERIOD_W = 26,
  parameter int CNT_W    = 16,
  parameter int ACK_TO   = 16,
  parameter int DONE_TO  = 1000000
) (
  input  logic                iclk,
  input  logic                ireset_n,
  input  logic [1:0]          imode,
  input  logic [PERIOD_W-1:0] iperiod,
  input  logic [BURST_W-1:0]  iburst_len,
  input  logic                istrobe,
  input  logic                itx_busy,
  output logic                oTX_INIT,
  output logic                oBUSY,
  output logic [CNT_W-1:0]    oFRAME_CNT,
  output logic [CNT_W-1:0]    oMISSED_CNT,
  output logic                oTIMEOUT
);

  localparam int WAIT_W = $clog2(maxOf(ACK_TO, DONE_TO) + 1);

  logic               r_strobe_d;
  logic [1:0]         r_mode_d;
  logic               r_pending;
  logic [BURST_W-1:0] r_burst;
  state_e             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_tx_init;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   r_missed_cnt;
  logic               r_timeout;

  logic w_edge;
  logic w_mode_chg;
  logic w_timer_en;
  logic w_tick;
  logic w_trigger;
  logic w_burst_req;
  logic w_idle;
  logic w_take;
  logic w_burst_load;
  logic w_miss;
  logic w_frame_done;

  // A mode change restarts everything source-related: the timer is held for
  // that cycle and no trigger or burst request from that cycle is honoured.
  assign w_edge       = istrobe & ~r_strobe_d;
  assign w_mode_chg   = (imode != r_mode_d);
  assign w_timer_en   = (imode == MODE_PERIODIC) && (iperiod != '0) && !w_mode_chg;
  assign w_trigger    = !w_mode_chg &&
                        (((imode == MODE_MANUAL) && w_edge) ||
                         ((imode == MODE_PERIODIC) && w_tick));
  assign w_burst_req  = !w_mode_chg && (imode == MODE_BURST) && w_edge;
  assign w_idle       = (r_state == ST_IDLE);
  assign w_take       = w_idle && !w_mode_chg && (r_pending || (r_burst != '0));
  assign w_burst_load = w_burst_req && w_idle && (r_burst == '0);
  assign w_miss       = (w_trigger && r_pending && !w_take) ||
                        (w_burst_req && !w_burst_load);
  assign w_frame_done = (r_state == ST_WAIT_DONE) && !itx_busy;

  assign oTX_INIT    = r_tx_init;
  assign oBUSY       = (r_state != ST_IDLE) || (r_burst != '0);
  assign oFRAME_CNT  = r_frame_cnt;
  assign oMISSED_CNT = r_missed_cnt;
  assign oTIMEOUT    = r_timeout;

  blvds_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .i_enable (w_timer_en),
    .i_period (iperiod),
    .o_tick   (w_tick)
  );

  // Previous strobe level for edge detection and previous mode for change detection
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_strobe_d <= 1'b0;
      r_mode_d   <= 2'd0;
    end else begin
      r_strobe_d <= istrobe;
      r_mode_d   <= imode;
    end
  end

  // One-deep pending trigger; a trigger landing on the cycle it is consumed re-arms it
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_pending <= 1'b0;
    end else if (w_mode_chg) begin
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pending <= w_trigger;
    end else if (w_trigger) begin
      r_pending <= 1'b1;
    end
  end

  // Frames left in the current burst; decremented as each frame is issued
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_burst <= '0;
    end else if (w_mode_chg) begin
      r_burst <= '0;
    end else if (w_take && (r_burst != '0)) begin
      r_burst <= r_burst - BURST_W'(1);
    end else if (w_burst_load) begin
      r_burst <= iburst_len;
    end
  end

  // Issue / acknowledge / completion handshake with bounded waits
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_tx_init <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_tx_init <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state   <= ST_ISSUE;
            r_tx_init <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_ACK;
          r_wait  <= '0;
        end
        ST_WAIT_ACK: begin
          if (itx_busy) begin
            r_state <= ST_WAIT_DONE;
            r_wait  <= '0;
          end else if (r_wait == WAIT_W'(ACK_TO - 1)) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!itx_busy) begin
            r_state <= ST_IDLE;
          end else if (r_wait == WAIT_W'(DONE_TO - 1)) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics: completed frames and dropped triggers
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_frame_cnt  <= '0;
      r_missed_cnt <= '0;
    end else begin
      if (w_frame_done && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (w_miss && (r_missed_cnt != '1)) begin
        r_missed_cnt <= r_missed_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_blvds_tx_scheduler.sv
// Self-checking bench for blvds_tx_scheduler: directed scenarios plus a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_blvds_tx_scheduler;

  localparam int PERIOD_W = 26;
  localparam int CNT_W    = 4;
  localparam int ACK_TO   = 16;
  localparam int DONE_TO  = 300;
  localparam int SAT      = (1 << CNT_W) - 1;
  localparam int VW       = 2 * CNT_W + 3;

  logic                iclk = 1'b0;
  logic                ireset_n = 1'b1;
  logic [1:0]          imode = 2'd0;
  logic [PERIOD_W-1:0] iperiod = '0;
  logic [7:0]          iburst_len = 8'd0;
  logic                istrobe = 1'b0;
  logic                itx_busy = 1'b0;
  wire                 oTX_INIT;
  wire                 oBUSY;
  wire [CNT_W-1:0]     oFRAME_CNT;
  wire [CNT_W-1:0]     oMISSED_CNT;
  wire                 oTIMEOUT;

  int checks = 0;
  int passed = 0;

  // Model state: phase 0 idle, 1 issuing, 2 awaiting ack, 3 awaiting done
  int mPrevStrobe, mPrevMode, mTimer, mPending, mBurst, mPhase, mAge;
  int mFrames, mMissed, mTimeout;

  // Generator stub: 0 normal response, 1 busy stuck low, 2 busy stuck high
  int stubMode = 0;
  int busyLen = 1;
  int busyLeft = 0;
  int stepCount = 0;
  int pulseCount = 0;
  int firstPulseStep = -1;

  always #5 iclk = ~iclk;

  blvds_tx_scheduler #(
    .PERIOD_W (PERIOD_W),
    .CNT_W    (CNT_W),
    .ACK_TO   (ACK_TO),
    .DONE_TO  (DONE_TO)
  ) dut (
    .iclk        (iclk),
    .ireset_n    (ireset_n),
    .imode       (imode),
    .iperiod     (iperiod),
    .iburst_len  (iburst_len),
    .istrobe     (istrobe),
    .itx_busy    (itx_busy),
    .oTX_INIT    (oTX_INIT),
    .oBUSY       (oBUSY),
    .oFRAME_CNT  (oFRAME_CNT),
    .oMISSED_CNT (oMISSED_CNT),
    .oTIMEOUT    (oTIMEOUT)
  );

  function automatic logic [VW-1:0] actVec();
    return {oTX_INIT, oBUSY, oFRAME_CNT, oMISSED_CNT, oTIMEOUT};
  endfunction

  function automatic logic [VW-1:0] expVec();
    logic eInit, eBusy, eTo;
    eInit = (mPhase == 1);
    eBusy = (mPhase != 0) || (mBurst > 0);
    eTo   = (mTimeout != 0);
    return {eInit, eBusy, CNT_W'(mFrames), CNT_W'(mMissed), eTo};
  endfunction

  task automatic modelReset();
    mPrevStrobe = 0; mPrevMode = 0; mTimer = 0; mPending = 0; mBurst = 0;
    mPhase = 0; mAge = 0; mFrames = 0; mMissed = 0; mTimeout = 0;
  endtask

  // Advance the model by one clock using the inputs applied before the edge
  task automatic modelStep();
    int  mode = int'(imode);
    int  per = int'(iperiod);
    bit  strobeEdge = istrobe && (mPrevStrobe == 0);
    bit  modeChg = (mode != mPrevMode);
    bit  tick = 0;
    bit  trig, bReq, take, miss;
    int  preBurst = mBurst;
    if (!modeChg && mode == 1 && per != 0) begin
      if (mTimer + 1 >= per) begin tick = 1; mTimer = 0; end
      else mTimer = mTimer + 1;
    end else begin
      mTimer = 0;
    end
    trig = !modeChg && ((mode == 0 && strobeEdge) || (mode == 1 && tick));
    bReq = !modeChg && mode == 2 && strobeEdge;
    take = (mPhase == 0) && !modeChg && (mPending != 0 || preBurst > 0);
    miss = 0;
    if (modeChg) begin
      mPending = 0;
      mBurst = 0;
    end else begin
      if (trig && mPending != 0 && !take) miss = 1;
      if (take) mPending = trig;
      else if (trig) mPending = 1;
      if (take && preBurst > 0) mBurst = preBurst - 1;
      if (bReq) begin
        if (preBurst == 0 && mPhase == 0) mBurst = int'(iburst_len);
        else miss = 1;
      end
    end
    if (miss && mMissed < SAT) mMissed++;
    case (mPhase)
      0: if (take) mPhase = 1;
      1: begin mPhase = 2; mAge = 0; end
      2: begin
        if (itx_busy) begin mPhase = 3; mAge = 0; end
        else begin
          mAge++;
          if (mAge >= ACK_TO) begin mPhase = 0; mTimeout = 1; end
        end
      end
      default: begin
        if (!itx_busy) begin
          mPhase = 0;
          if (mFrames < SAT) mFrames++;
        end else begin
          mAge++;
          if (mAge >= DONE_TO) begin mPhase = 0; mTimeout = 1; end
        end
      end
    endcase
    mPrevStrobe = istrobe;
    mPrevMode = mode;
  endtask

  // One clock: model update at the edge, sample outputs 1 time unit later, stub reacts
  task automatic step();
    @(posedge iclk);
    modelStep();
    #1;
    stepCount++;
    if (oTX_INIT) begin
      if (pulseCount == 0) firstPulseStep = stepCount;
      pulseCount++;
    end
    case (stubMode)
      1: itx_busy = 1'b0;
      2: itx_busy = 1'b1;
      default: begin
        if (busyLeft > 0) begin
          busyLeft--;
          if (busyLeft == 0) itx_busy = 1'b0;
        end
        if (oTX_INIT) begin
          itx_busy = 1'b1;
          busyLeft = busyLen;
        end
      end
    endcase
  endtask

  task automatic doReset();
    ireset_n = 1'b0;
    istrobe = 1'b0; itx_busy = 1'b0; imode = 2'd0; iperiod = '0; iburst_len = 8'd0;
    stubMode = 0; busyLeft = 0;
    repeat (2) @(posedge iclk);
    #1;
    ireset_n = 1'b1;
    modelReset();
    pulseCount = 0;
    firstPulseStep = -1;
  endtask

  task automatic test_reset();
    #2;
    ireset_n = 1'b0;
    #1;
    checks++;
    if (actVec() !== '0) $display("[TB] FAIL reset_async: got %h, want 0", actVec());
    else passed++;
    repeat (2) @(posedge iclk);
    #1;
    checks++;
    if (actVec() !== '0) $display("[TB] FAIL reset_held: got %h, want 0", actVec());
    else passed++;
    doReset();
  endtask

  task automatic test_manual();
    int startStep;
    doReset();
    imode = 2'd0; busyLen = 10;
    repeat (3) step();
    istrobe = 1'b1;
    startStep = stepCount;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 5) istrobe = 1'b0;
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL manual_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (firstPulseStep - startStep !== 2)
      $display("[TB] FAIL manual_latency: got %0d, want 2", firstPulseStep - startStep);
    else passed++;
    checks++;
    if (pulseCount !== 1) $display("[TB] FAIL manual_pulses: got %0d, want 1", pulseCount);
    else passed++;
    checks++;
    if (oFRAME_CNT !== CNT_W'(1) || oBUSY !== 1'b0)
      $display("[TB] FAIL manual_done: frames %0d busy %b, want 1 0", oFRAME_CNT, oBUSY);
    else passed++;
  endtask

  task automatic test_periodic();
    int prev = -1;
    doReset();
    imode = 2'd1; iperiod = PERIOD_W'(100); busyLen = 20;
    for (int i = 0; i < 1050; i++) begin
      step();
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL periodic_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
      if (oTX_INIT) begin
        if (prev >= 0) begin
          checks++;
          if (stepCount - prev !== 100)
            $display("[TB] FAIL periodic_interval: got %0d, want 100", stepCount - prev);
          else passed++;
        end
        prev = stepCount;
      end
    end
    checks++;
    if (pulseCount !== 10 || oMISSED_CNT !== '0)
      $display("[TB] FAIL periodic_totals: pulses %0d missed %0d, want 10 0", pulseCount, oMISSED_CNT);
    else passed++;
  endtask

  task automatic test_overrun();
    doReset();
    imode = 2'd1; iperiod = PERIOD_W'(10); busyLen = 35;
    for (int i = 0; i < 700; i++) begin
      step();
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL overrun_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (oMISSED_CNT !== CNT_W'(SAT) || oFRAME_CNT !== CNT_W'(SAT))
      $display("[TB] FAIL overrun_saturate: missed %0d frames %0d, want %0d %0d",
               oMISSED_CNT, oFRAME_CNT, SAT, SAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit second = 0;
    int offAt = -1;
    doReset();
    imode = 2'd2; iburst_len = 8'd5; busyLen = 8;
    repeat (2) step();
    istrobe = 1'b1;
    offAt = stepCount + 3;
    for (int i = 0; i < 120; i++) begin
      step();
      if (stepCount == offAt) istrobe = 1'b0;
      if (pulseCount == 2 && !second) begin
        second = 1;
        istrobe = 1'b1;
        offAt = stepCount + 3;
      end
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL burst_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (pulseCount !== 5 || oFRAME_CNT !== CNT_W'(5) || oMISSED_CNT !== CNT_W'(1) || oBUSY !== 1'b0)
      $display("[TB] FAIL burst_totals: pulses %0d frames %0d missed %0d busy %b, want 5 5 1 0",
               pulseCount, oFRAME_CNT, oMISSED_CNT, oBUSY);
    else passed++;
  endtask

  task automatic test_timeout();
    int toStep = -1;
    doReset();
    imode = 2'd0; stubMode = 1;
    step();
    istrobe = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (oTIMEOUT && toStep < 0) toStep = stepCount;
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL ack_to_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (toStep - firstPulseStep !== ACK_TO + 1 || oFRAME_CNT !== '0 || oBUSY !== 1'b0)
      $display("[TB] FAIL ack_timeout: delay %0d frames %0d busy %b, want %0d 0 0",
               toStep - firstPulseStep, oFRAME_CNT, oBUSY, ACK_TO + 1);
    else passed++;

    toStep = -1;
    doReset();
    imode = 2'd0; stubMode = 2;
    repeat (2) step();
    istrobe = 1'b1;
    for (int i = 0; i < DONE_TO + 30; i++) begin
      step();
      if (oTIMEOUT && toStep < 0) toStep = stepCount;
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL done_to_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (toStep - firstPulseStep !== DONE_TO + 2 || oFRAME_CNT !== '0 || oBUSY !== 1'b0)
      $display("[TB] FAIL done_timeout: delay %0d frames %0d busy %b, want %0d 0 0",
               toStep - firstPulseStep, oFRAME_CNT, oBUSY, DONE_TO + 2);
    else passed++;
  endtask

  task automatic test_mode_switch();
    bit switched = 0;
    doReset();
    imode = 2'd2; iburst_len = 8'd5; busyLen = 8;
    step();
    istrobe = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 3) istrobe = 1'b0;
      if (pulseCount == 2 && !switched) begin
        switched = 1;
        imode = 2'd3;
      end
      checks++;
      if (actVec() !== expVec())
        $display("[TB] FAIL switch_lockstep step %0d: got %h, want %h", stepCount, actVec(), expVec());
      else passed++;
    end
    checks++;
    if (pulseCount !== 2 || oFRAME_CNT !== CNT_W'(2) || oBUSY !== 1'b0)
      $display("[TB] FAIL switch_totals: pulses %0d frames %0d busy %b, want 2 2 0",
               pulseCount, oFRAME_CNT, oBUSY);
    else passed++;

    imode = 2'd2;
    step();
    istrobe = 1'b1;
    for (int i = 0; i < 30 && pulseCount < 3; i++) step();
    repeat (3) step();
    checks++;
    if (oBUSY !== 1'b1) $display("[TB] FAIL midframe_busy: got %b, want 1", oBUSY);
    else passed++;
    #2;
    ireset_n = 1'b0;
    #1;
    checks++;
    if (actVec() !== '0) $display("[TB] FAIL midframe_async_reset: got %h, want 0", actVec());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge iclk);
      #1;
      checks++;
      if (actVec() !== '0) $display("[TB] FAIL reset_no_glitch: got %h, want 0", actVec());
      else passed++;
    end
    doReset();
  endtask

  task automatic test_random();
    doReset();
    for (int seg = 0; seg < 12; seg++) begin
      imode = 2'($urandom_range(0, 3));
      iperiod = PERIOD_W'($urandom_range(0, 25));
      iburst_len = 8'($urandom_range(0, 6));
      busyLen = $urandom_range(1, 15);
      stubMode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      for (int i = 0; i < 150; i++) begin
        step();
        if ($urandom_range(0, 5) == 0) istrobe = ~istrobe;
        checks++;
        if (actVec() !== expVec())
          $display("[TB] FAIL random_lockstep seg %0d step %0d: got %h, want %h",
                   seg, stepCount, actVec(), expVec());
        else passed++;
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_manual();
    test_periodic();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_mode_switch();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
